// File: rtl/cmd_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : cmd_reg_bank
// Description : Bank of command-loaded configuration registers. Writes land
//               in shadow registers; a commit command copies every shadow to
//               the active outputs in one cycle, a revert does the reverse.
//               Optional readback of a shadow or active value over a
//               valid/ready handshake, enabled by defining
//               CMD_REG_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_reg_bank #(
    parameter int                 CMD_W         = 16,
    parameter int                 ADDR_W        = 4,
    parameter int                 VALUE_W       = 12,
    parameter int                 N_REGS        = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR     = '0,
    parameter logic [ADDR_W-1:0]  COMMIT_ADDR   = 4'hE,
    parameter logic [ADDR_W-1:0]  READ_ADDR     = 4'hF,
    parameter logic [VALUE_W-1:0] DEFAULT_VALUE = '0
) (
    input  logic                      Clk_In,
    input  logic                      Rst,
    input  logic [CMD_W-1:0]          Cmd_In,
    input  logic                      Cmd_En,
    output logic [N_REGS*VALUE_W-1:0] Reg_Out,
    output logic                      Commit_Pulse,
    output logic                      Err_Pulse,
    output logic [VALUE_W-1:0]        Rd_Data,
    output logic                      Rd_Valid,
    input  logic                      Rd_Ready
);

    localparam logic [ADDR_W-1:0] c_N_REGS_A = ADDR_W'(N_REGS);

    // Command field decode
    logic [ADDR_W-1:0]  w_addr;
    logic [ADDR_W-1:0]  w_widx;
    logic [VALUE_W-1:0] w_value;
    logic               w_is_write;
    logic               w_is_commit_cmd;
    logic               w_do_commit;
    logic               w_do_revert;
    logic               w_is_read;

    assign w_addr          = Cmd_In[CMD_W-1 -: ADDR_W];
    assign w_value         = Cmd_In[VALUE_W-1:0];
    // Wrapping subtract folds both range bounds into one compare; the
    // register window always sits below COMMIT_ADDR.
    assign w_widx          = w_addr - BASE_ADDR;
    assign w_is_write      = Cmd_En && (w_widx < c_N_REGS_A);
    assign w_is_commit_cmd = Cmd_En && (w_addr == COMMIT_ADDR);
    assign w_do_commit     = w_is_commit_cmd && Cmd_In[0];
    assign w_do_revert     = w_is_commit_cmd && !Cmd_In[0] && Cmd_In[1];
    assign w_is_read       = Cmd_En && (w_addr == READ_ADDR);

    logic [VALUE_W-1:0] r_shadow [N_REGS];
    logic [VALUE_W-1:0] r_active [N_REGS];
    logic               r_commit_pulse;

    // Shadow writes, commit (shadow -> active) and revert (active -> shadow)
    always_ff @(posedge Clk_In) begin
        if (Rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_shadow[i] <= DEFAULT_VALUE;
                r_active[i] <= DEFAULT_VALUE;
            end
            r_commit_pulse <= 1'b0;
        end else begin
            r_commit_pulse <= w_do_commit;
            for (int i = 0; i < N_REGS; i++) begin
                if (w_do_commit) begin
                    r_active[i] <= r_shadow[i];
                end
                if (w_do_revert) begin
                    r_shadow[i] <= r_active[i];
                end else if (w_is_write && (w_widx == ADDR_W'(i))) begin
                    r_shadow[i] <= w_value;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < N_REGS; g++) begin : g_reg_out
            assign Reg_Out[g*VALUE_W +: VALUE_W] = r_active[g];
        end
    endgenerate

    assign Commit_Pulse = r_commit_pulse;

`ifdef CMD_REG_READBACK_EN
    // One extra index bit so out-of-range indices can be requested and flagged
    localparam int   c_IDX_W   = $clog2(N_REGS) + 1;
    localparam logic c_ST_IDLE = 1'b0;
    localparam logic c_ST_HOLD = 1'b1;

    logic               r_state;
    logic               w_state_nxt;
    logic [VALUE_W-1:0] r_rd_data;
    logic [VALUE_W-1:0] w_rd_data_nxt;
    logic [VALUE_W-1:0] w_rd_value;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_accept;
    logic               w_handshake;
    logic [c_IDX_W-1:0] w_ridx;
    logic               w_ridx_ok;
    logic               w_rsel_shadow;

    assign w_ridx        = Cmd_In[c_IDX_W-1:0];
    assign w_ridx_ok     = (w_ridx < c_IDX_W'(N_REGS));
    assign w_rsel_shadow = Cmd_In[CMD_W-ADDR_W-1];
    assign w_handshake   = (r_state == c_ST_HOLD) && Rd_Ready;

    // Selected register value for a read; zero when the index is out of range
    always_comb begin
        w_rd_value = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (w_ridx == c_IDX_W'(i)) begin
                w_rd_value = w_rsel_shadow ? r_shadow[i] : r_active[i];
            end
        end
    end

    // Readback next-state: accept when idle or when the held word is taken
    always_comb begin
        w_state_nxt   = r_state;
        w_rd_data_nxt = r_rd_data;
        w_err_nxt     = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_accept = w_is_read;
            end
            c_ST_HOLD: begin
                if (w_handshake) begin
                    w_state_nxt = c_ST_IDLE;
                    w_accept    = w_is_read;
                end else if (w_is_read) begin
                    w_err_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (w_accept) begin
            w_state_nxt   = c_ST_HOLD;
            w_rd_data_nxt = w_rd_value;
            w_err_nxt     = !w_ridx_ok;
        end
    end

    // Readback state, held data and error pulse registers
    always_ff @(posedge Clk_In) begin
        if (Rst) begin
            r_state   <= c_ST_IDLE;
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign Rd_Valid  = (r_state == c_ST_HOLD);
    assign Rd_Data   = r_rd_data;
    assign Err_Pulse = r_err;
`else
    logic r_err;
    logic w_unused_rd_ready;

    assign w_unused_rd_ready = Rd_Ready;

    // Without readback a read request is an invalid command
    always_ff @(posedge Clk_In) begin
        if (Rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_is_read;
        end
    end

    assign Rd_Valid  = 1'b0;
    assign Rd_Data   = '0;
    assign Err_Pulse = r_err;
`endif

endmodule
`default_nettype wire
